// File: rtl/regfile_bank_sel_lvt_if.sv
// Bundle for the live-value-table read and commit ports plus the clear/ready pair.
// Latency: none; the bundle only carries wires.
// Backpressure: none; the bundle carries no ready signal, and init_done low means retires are dropped.
interface regfile_bank_sel_lvt_if #(
  parameter int NUM_REGS    = 32,
  parameter int READ_PORTS  = 2,
  parameter int WRITE_PORTS = 2,
  parameter int SEL_W       = $clog2(WRITE_PORTS)
);
  localparam int AW = $clog2(NUM_REGS);

  logic                               clear;
  logic                               init_done;
  logic [READ_PORTS-1:0][AW-1:0]      rs_addr;
  logic [READ_PORTS-1:0][SEL_W-1:0]   rs_sel;
  logic [WRITE_PORTS-1:0][AW-1:0]     rd_addr;
  logic [WRITE_PORTS-1:0]             rd_retired;

  modport master (
    output clear, rs_addr, rd_addr, rd_retired,
    input  init_done, rs_sel
  );

  modport slave (
    input  clear, rs_addr, rd_addr, rd_retired,
    output init_done, rs_sel
  );
endinterface

// File: rtl/regfile_bank_sel_lvt.sv
// XOR live-value table: tracks which write bank holds each register's latest value.
// Latency: rs_sel is combinational; a retire becomes visible through the table on the next cycle, or in the same cycle with BYPASS.
// Backpressure: none; retires are accepted when init_done is high and dropped during the clear sweep.
module regfile_bank_sel_lvt #(
  parameter int NUM_REGS    = 32,
  parameter int READ_PORTS  = 2,
  parameter int WRITE_PORTS = 2,
  parameter int SEL_W       = $clog2(WRITE_PORTS),
  parameter int BYPASS      = 1,
  parameter int ZERO_REG    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  regfile_bank_sel_lvt_if.slave bus
);
  localparam int AW = $clog2(NUM_REGS);

  typedef enum logic {CLEAR, READY} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic            ready;

  // Banks are LUTRAM-style storage with no reset; the sweep zeroes them instead.
  logic [SEL_W-1:0] bank_q [WRITE_PORTS][NUM_REGS];

  logic [WRITE_PORTS-1:0]             base_we;
  logic [WRITE_PORTS-1:0]             we;
  logic [WRITE_PORTS-1:0][SEL_W-1:0]  new_sel;

  assign ready         = (state_q == READY);
  assign bus.init_done = ready;

  // Sweep state and counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Sweep sequencing: clear restarts at entry 0; the last entry hands over to READY without wrapping.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (bus.clear) begin
      state_d = CLEAR;
      cnt_d   = '0;
    end else if (state_q == CLEAR) begin
      if (cnt_q == AW'(NUM_REGS - 1)) begin
        state_d = READY;
      end else begin
        cnt_d = cnt_q + AW'(1);
      end
    end
  end

  // Qualify retires; on a same-address collision only the highest port keeps its write.
  always_comb begin
    base_we = '0;
    we      = '0;
    for (int i = 0; i < WRITE_PORTS; i++) begin
      base_we[i] = bus.rd_retired[i] && ready &&
                   ((ZERO_REG == 0) || (bus.rd_addr[i] != '0));
    end
    for (int i = 0; i < WRITE_PORTS; i++) begin
      we[i] = base_we[i];
      for (int j = i + 1; j < WRITE_PORTS; j++) begin
        if (base_we[j] && (bus.rd_addr[j] == bus.rd_addr[i])) begin
          we[i] = 1'b0;
        end
      end
    end
  end

  // Encode each port's value so the XOR across all banks equals the port index.
  always_comb begin
    new_sel = '0;
    for (int i = 0; i < WRITE_PORTS; i++) begin
      new_sel[i] = SEL_W'(i);
      for (int j = 0; j < WRITE_PORTS; j++) begin
        if (j != i) begin
          new_sel[i] = new_sel[i] ^ bank_q[j][bus.rd_addr[i]];
        end
      end
    end
  end

  // Bank writes: the sweep zeroes one entry per cycle, otherwise each port writes its own bank.
  always_ff @(posedge clk) begin
    for (int i = 0; i < WRITE_PORTS; i++) begin
      if (state_q == CLEAR) begin
        bank_q[i][cnt_q] <= '0;
      end else if (we[i]) begin
        bank_q[i][bus.rd_addr[i]] <= new_sel[i];
      end
    end
  end

  // Read: XOR of all banks, overridden by a same-cycle winner, forced to 0 for x0 and during the sweep.
  always_comb begin
    bus.rs_sel = '0;
    for (int k = 0; k < READ_PORTS; k++) begin
      for (int j = 0; j < WRITE_PORTS; j++) begin
        bus.rs_sel[k] = bus.rs_sel[k] ^ bank_q[j][bus.rs_addr[k]];
      end
      if (BYPASS != 0) begin
        for (int i = 0; i < WRITE_PORTS; i++) begin
          if (we[i] && (bus.rd_addr[i] == bus.rs_addr[k])) begin
            bus.rs_sel[k] = SEL_W'(i);
          end
        end
      end
      if ((ZERO_REG != 0) && (bus.rs_addr[k] == '0)) begin
        bus.rs_sel[k] = '0;
      end
      if (!ready) begin
        bus.rs_sel[k] = '0;
      end
    end
  end
endmodule

// File: doc/regfile_bank_sel_lvt.md
# regfile_bank_sel_lvt

Parametrised XOR live-value table that tracks, for each architectural register, which register-file write bank holds the most recent value. It sits beside the banked register file. Each commit port writes its own bank, and each read port uses `rs_sel` to pick the bank to read.

Compared with the earlier bank selector, this block adds:
- configurable register count and port counts;
- a hardware clear sweep, because LUTRAM tables cannot be reset;
- optional same-cycle write-to-read bypass;
- x0 write suppression;
- defined behaviour for same-address write collisions.

## Interface
Parameters:
- `NUM_REGS`, default 32, number of tracked registers (power of two, at least 2).
- `READ_PORTS`, default 2, number of read ports.
- `WRITE_PORTS`, default 2, number of commit ports (at least 2).
- `SEL_W`, default `$clog2(WRITE_PORTS)`, width of a bank select.
- `BYPASS`, default 1. When 1, a read sees a same-cycle retire. When 0, the retire becomes visible on the next cycle.
- `ZERO_REG`, default 1. When 1, writes to address 0 are dropped and address 0 always reads select 0.

Ports (reset is synchronous and active-high; one clock):
- `clk`  in  1  clock.
- `rst`  in  1  synchronous active-high reset; starts a clear sweep.
- `clear`  in  1  synchronous request to restart the clear sweep.
- `init_done`  out  1  table is valid; writes are accepted.
- `rs_addr`  in  `READ_PORTS` x `$clog2(NUM_REGS)`  read addresses.
- `rs_sel`  out  `READ_PORTS` x `SEL_W`  bank holding the latest value of each `rs_addr`.
- `rd_addr`  in  `WRITE_PORTS` x `$clog2(NUM_REGS)`  commit addresses.
- `rd_retired`  in  `WRITE_PORTS` x 1  per-port commit strobe.

## Operation
Storage:
- There are `WRITE_PORTS` banks, each holding `NUM_REGS` x `SEL_W` bits.
- Bank i has one write port, driven by commit port i.
- Each bank has `WRITE_PORTS-1+READ_PORTS` asynchronous read ports.

Commit encoding:
- An effective write on port i stores `new_sel[i] = i ^ (XOR over j != i of bank[j][rd_addr[i]])` into `bank[i][rd_addr[i]]`.
- After the write, the XOR across all banks at that address equals i.

Read:
- `rs_sel[k]` is the XOR over all banks of `bank[j][rs_addr[k]]`.

Effective-write conditions. Write i is effective when all of the following hold:
- `rd_retired[i]` is high;
- `init_done` is high;
- the address is not 0, or `ZERO_REG` is 0;
- no higher-indexed port j is effectively retiring the same `rd_addr` in the same cycle.

Collision rule: on a same-address collision, the highest port index wins and lower-indexed writes are dropped.

Bypass (`BYPASS`=1):
- If any effective write targets `rs_addr[k]`, `rs_sel[k]` equals the index of the winning port that cycle.
- Otherwise `rs_sel[k]` follows the table read.

Address 0 (`ZERO_REG`=1): `rs_sel` is 0 for address 0 regardless of table contents.

Clear sweep state machine, with states CLEAR and READY:
- `rst` or `clear` forces CLEAR with counter = 0.
- In CLEAR, each cycle writes 0 to entry `counter` in every bank, then increments the counter.
- At `counter == NUM_REGS-1`, the state moves to READY on the next edge. The counter does not wrap.
- `clear` asserted during CLEAR restarts the counter at 0.
- Reset asserted mid-sweep restarts the sweep at 0.
- While in CLEAR:
  - `init_done` is 0;
  - all `rd_retired` are ignored;
  - `rs_sel` outputs 0.
- Callers must not retire during CLEAR. The block drops those retires; it does not queue them.

## Timing
- Reset values:
  - state CLEAR, counter 0, `init_done` 0, `rs_sel` all 0.
  - Table contents are undefined until the sweep completes.
- `init_done` rises exactly `NUM_REGS` cycles after the first cycle with `rst` low (32 cycles at defaults).
- It falls on the edge after `clear` is sampled.
- `rs_sel` is combinational from `rs_addr`, bank contents and, with bypass, same-cycle `rd_addr`/`rd_retired`.
- Write latency:
  - A retire at edge t is visible through the table from cycle t+1.
  - With `BYPASS`=1 it is also visible in cycle t, combinationally.
- Simultaneous retires to different addresses all take effect. Their `new_sel` values read pre-edge contents, which is correct because the addresses differ.
- There is no internal pipeline and no back-pressure. A retire is accepted in the cycle it is presented, provided `init_done` is 1.

## Test plan
1. Reset and sweep: assert `rst` for 1 cycle at defaults.
   - `init_done` is 0 for cycles 1–31 after release and 1 on cycle 32.
   - `rs_sel` is 0 for all 32 addresses.
2. Single write and bypass: retire port 1 to addr 5.
   - Same cycle: `rs_sel` for addr 5 is 1 (`BYPASS`=1).
   - Next cycle: `rs_sel` is still 1.
   - Retire port 0 to addr 5: `rs_sel` becomes 0.
3. Collision: ports 0 and 1 both retire addr 7 in the same cycle.
   - `rs_sel`(7) is 1.
   - A later port-0 retire to addr 7 yields 0.
4. x0 suppression: retire port 1 to addr 0, then read addr 0.
   - `rs_sel` is 0 in that cycle and afterwards.
5. Clear mid-operation:
   - Populate addrs 1–4 with port 1.
   - Pulse `clear` at sweep counter 0, then pulse it again at counter 10.
   - `init_done` returns 1 exactly 32 cycles after the second pulse.
   - Retires issued during the sweep are ignored.
   - All `rs_sel` read 0.
6. Random multi-port run with `WRITE_PORTS`=4, `READ_PORTS`=3, `BYPASS`=0, 10k cycles against a scoreboard of last writer per address. Every `rs_sel` matches the scoreboard one cycle after each retire.
